// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control constants and sequencer state codes.
// Used by the multiplier sequencer and its bus interface.
package alu_ctrl_pkg;

  localparam int WIDTH      = 16;
  localparam int ITERATIONS = WIDTH;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [4:0] CNT_LAST = 5'(ITERATIONS - 1);

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Control-unit handshake bundle for the multiplier sequencer.
// The master is the CPU control unit; the slave is the sequencer.
interface alu_mul_sequencer_if;
  import alu_ctrl_pkg::*;

  logic                 Start;
  logic [WIDTH-1:0]     OpA;
  logic [WIDTH-1:0]     OpB;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   Product;

  modport master (
    output Start, OpA, OpB,
    input  Busy, Done, Product
  );

  modport slave (
    input  Start, OpA, OpB,
    output Busy, Done, Product
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add 16x16 multiplier time-sharing the external ALU.
// Define MUL_SIGNED_EN for radix-2 Booth (two's complement).
module alu_mul_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  alu_mul_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]      AluA,
  output logic [WIDTH-1:0]      AluB,
  output logic [2:0]            AluOp,
  output logic                  AluBNegate,
  input  logic [WIDTH-1:0]      AluResult,
  input  logic                  AluCarryOut,
  input  logic                  AluOverflow
);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [4:0]         cnt;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               new_msb;

`ifdef MUL_SIGNED_EN
  logic               qm1;

  // Sign of the true 17-bit sum, recovered from overflow.
  assign new_msb = AluResult[WIDTH-1] ^ AluOverflow;
`else
  logic               unused_ovf;

  assign unused_ovf = AluOverflow;
  // Unsigned carry becomes the new top bit of Hi.
  assign new_msb    = AluCarryOut;
`endif

  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Product = product;

  // ALU is driven only while running; idle values otherwise.
  always_comb begin
    AluA       = '0;
    AluB       = '0;
    AluOp      = ALU_OP_ADD;
    AluBNegate = 1'b0;
    if (state == RUN) begin
      AluA = hi;
`ifdef MUL_SIGNED_EN
      unique case ({lo[0], qm1})
        2'b01: AluB = mcand;
        2'b10: begin
          AluB       = mcand;
          AluBNegate = 1'b1;
        end
        default: AluB = '0;
      endcase
`else
      AluB = lo[0] ? mcand : '0;
`endif
    end
  end

  // Control FSM plus partial-product register file.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
`ifdef MUL_SIGNED_EN
      qm1     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (done) begin
            busy <= 1'b0;
          end else if (bus.Start) begin
            mcand <= bus.OpA;
            hi    <= '0;
            lo    <= bus.OpB;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef MUL_SIGNED_EN
            qm1   <= 1'b0;
`endif
          end
        end
        RUN: begin
          hi  <= {new_msb, AluResult[WIDTH-1:1]};
          lo  <= {AluResult[0], lo[WIDTH-1:1]};
          cnt <= cnt + 5'd1;
`ifdef MUL_SIGNED_EN
          qm1 <= lo[0];
`endif
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          product <= {hi, lo};
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a reference ALU.
// Build with MUL_SIGNED_EN to exercise the Booth variant.
module tb_alu_mul_sequencer;
  import alu_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [2:0]  AluOp;
  logic        AluBNegate;
  logic [15:0] AluResult;
  logic        AluCarryOut;
  logic        AluOverflow;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] sb[$];

  alu_mul_sequencer_if bus ();

  always #5 Clock = ~Clock;

  alu_mul_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus),
    .AluA        (AluA),
    .AluB        (AluB),
    .AluOp       (AluOp),
    .AluBNegate  (AluBNegate),
    .AluResult   (AluResult),
    .AluCarryOut (AluCarryOut),
    .AluOverflow (AluOverflow)
  );

  logic [15:0] bx;
  logic [16:0] sum17;
  logic [15:0] sum15;

  // Reference 16-bit ALU: AND, OR, ADD with BNegate.
  always_comb begin
    bx          = AluBNegate ? ~AluB : AluB;
    sum17       = {1'b0, AluA} + {1'b0, bx}
                + 17'(AluBNegate);
    sum15       = {1'b0, AluA[14:0]} + {1'b0, bx[14:0]}
                + 16'(AluBNegate);
    AluResult   = '0;
    AluCarryOut = 1'b0;
    AluOverflow = 1'b0;
    case (AluOp)
      ALU_OP_AND: AluResult = AluA & bx;
      ALU_OP_OR:  AluResult = AluA | bx;
      ALU_OP_ADD: begin
        AluResult   = sum17[15:0];
        AluCarryOut = sum17[16];
        AluOverflow = sum17[16] ^ sum15[15];
      end
      default: AluResult = '0;
    endcase
  end

  function automatic logic [31:0] ref_mul(
    input logic [15:0] a,
    input logic [15:0] b
  );
`ifdef MUL_SIGNED_EN
    int sa;
    int sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    return 32'(sa * sb_);
`else
    return {16'b0, a} * {16'b0, b};
`endif
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Monitor: every Done pulse pops one expected product.
  always @(negedge Clock) begin
    if (!Reset && bus.Done === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got product %h want none",
                 bus.Product);
      end else begin
        chk("product", bus.Product, sb.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic run_op(
    input logic [15:0] a,
    input logic [15:0] b,
    input bit          poke
  );
    int n;
    logic [31:0] e;
    e = ref_mul(a, b);
    bus.OpA   = a;
    bus.OpB   = b;
    bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    bus.OpA   = 16'($urandom);
    bus.OpB   = 16'($urandom);
    chk("busy_after_start", 32'(bus.Busy), 32'd1);
    sb.push_back(e);
    n = 0;
    while (bus.Done !== 1'b1 && n < 40) begin
      if (poke && n == 5) begin
        bus.OpA   = 16'd7;
        bus.OpB   = 16'd7;
        bus.Start = 1'b1;
      end else begin
        bus.Start = 1'b0;
      end
      tick;
      n++;
    end
    bus.Start = 1'b0;
    chk("latency", 32'(n), 32'd17);
    chk("busy_in_done", 32'(bus.Busy), 32'd1);
    tick;
    chk("busy_after_done", 32'(bus.Busy), 32'd0);
    chk("done_one_cycle", 32'(bus.Done), 32'd0);
    chk("product_hold", bus.Product, e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int last;
    logic [15:0] ra;
    logic [15:0] rb;

    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.OpA   = '0;
    bus.OpB   = '0;
    tick;
    tick;
    Reset = 1'b0;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_product", bus.Product, 32'd0);
    chk("rst_alua", 32'(AluA), 32'd0);
    chk("rst_aluop", 32'(AluOp), 32'(ALU_OP_ADD));

    run_op(16'd3, 16'd5, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);

    // Abort mid-run; Start with Reset must lose.
    bus.OpA   = 16'd100;
    bus.OpB   = 16'd200;
    bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    repeat (8) tick;
    Reset     = 1'b1;
    bus.Start = 1'b1;
    tick;
    Reset     = 1'b0;
    bus.Start = 1'b0;
    sb.delete();
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_done", 32'(bus.Done), 32'd0);
    chk("abort_product", bus.Product, 32'd0);
    chk("abort_alua", 32'(AluA), 32'd0);
    chk("abort_alub", 32'(AluB), 32'd0);
    chk("abort_aluop", 32'(AluOp), 32'(ALU_OP_ADD));
    chk("abort_bneg", 32'(AluBNegate), 32'd0);
    tick;
    chk("abort_no_accept", 32'(bus.Busy), 32'd0);
    run_op(16'd100, 16'd200, 1'b0);

    run_op(16'h1234, 16'h0000, 1'b1);
    repeat (25) tick;
    chk("ignored_start_busy", 32'(bus.Busy), 32'd0);
    chk("ignored_start_prod", bus.Product, 32'd0);

    // Start held high: three back-to-back operations.
    bus.OpA   = 16'd2;
    bus.OpB   = 16'd9;
    bus.Start = 1'b1;
    repeat (3) sb.push_back(ref_mul(16'd2, 16'd9));
    k    = 0;
    n    = 0;
    last = -1;
    while (k < 3 && n < 100) begin
      tick;
      n++;
      if (bus.Done === 1'b1) begin
        k++;
        if (k == 3) bus.Start = 1'b0;
        if (last >= 0) chk("b2b_period", 32'(n - last), 32'd19);
        last = n;
        tick;
        n++;
        chk("b2b_idle_alua", 32'(AluA), 32'd0);
        chk("b2b_idle_alub", 32'(AluB), 32'd0);
        chk("b2b_idle_busy", 32'(bus.Busy), 32'd0);
      end
    end
    bus.Start = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    tick;

`ifdef MUL_SIGNED_EN
    run_op(16'hFFFD, 16'd5, 1'b0);
    chk("signed_neg3x5", bus.Product, 32'hFFFFFFF1);
    run_op(16'h8000, 16'h8000, 1'b0);
    chk("signed_min_sq", bus.Product, 32'h40000000);
    run_op(16'h7FFF, 16'h8000, 1'b0);
    chk("signed_max_min", bus.Product, 32'hC0008000);
`endif

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) ra = 16'hFFFF;
      if (i == 1) rb = 16'h8000;
      run_op(ra, rb, 1'b0);
    end

    repeat (3) tick;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
